text_typewriter_ctrl: RTL and testbench
=======================================

# text_typewriter_ctrl

Sequencer that drives one character-render stage from a stored text message, revealing it one glyph at a time (typewriter effect). It sits directly upstream of the character stage. It watches the pixel coordinates in the RGB stream and, for every pixel, supplies the character code and glyph-cell origin the stage must render. The message is loaded through a valid/ready byte port and played back on a start pulse.

## Interface
Parameters:
- MSG_LEN, 16, message buffer depth in characters (power of two, 2..64)
- GSIZE, 16, glyph cell size in screen pixels (8, 16 or 32)
- X0, 64, screen X of first cell origin; X0 + MSG_LEN*GSIZE ≤ 1024
- Y0, 32, screen Y of text row origin; Y0 + GSIZE ≤ 1024
- FRAME_DIV, 8, frames between successive character reveals (≥1)
- HOLD_FRAMES, 60, frames full message stays visible before done (≥1)

Ports:
- px_clk  in  1  pixel clock, single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- RGBStr_i  in  26  input RGB stream; only `XC`/`YC` fields (Pxs.vh) are decoded
- wr_valid  in  1  message byte valid
- wr_data  in  8  message byte (character code)
- wr_last  in  1  marks final byte of message
- wr_ready  out  1  byte accepted when wr_valid && wr_ready
- start  in  1  one-cycle pulse, begins playback
- RGBStr_o  out  26  RGBStr_i delayed one cycle
- character  out  8  code for current pixel's cell
- posx_o  out  10  X origin of current cell
- posy_o  out  10  Y origin of current cell
- busy  out  1  high in TYPE and HOLD
- done  out  1  one-cycle pulse at end of HOLD

## Operation
- States: IDLE, TYPE, HOLD. Reset -> IDLE, buffer length 0, write pointer 0, visible count 0.
- IDLE: wr_ready = !start. Accepted byte written at wr_ptr. wr_ptr increments; on wr_last or wr_ptr == MSG_LEN-1, len <= wr_ptr+1 and wr_ptr <= 0. Bytes beyond MSG_LEN are impossible (pointer wraps with len captured).
- IDLE + start, len != 0: visible <= 1, frame counter <= 0, -> TYPE. start with len == 0 ignored.
- Frame tick: one-cycle pulse when XC == 0 && YC == 0 and the previous cycle was not (0,0).
- TYPE: on each tick, counter increments. When counter == FRAME_DIV-1: counter <= 0, visible++. When visible reaches len, -> HOLD with counter <= 0.
- HOLD: on each tick, counter increments. When counter == HOLD_FRAMES-1: done pulses, visible <= 0, -> IDLE. Buffer and len are retained, so start replays the message.
- start in TYPE/HOLD ignored. wr_valid outside IDLE is not accepted (wr_ready=0).
- Cell decode per pixel, 10-bit unsigned arithmetic:
  - in_row = YC ≥ Y0 && YC < Y0+GSIZE.
  - in_col = XC ≥ X0 (compare before subtract).
  - idx = (XC−X0) >> log2(GSIZE).
  - If in_row && in_col && idx < visible: character = buf[idx], posx_o = X0 + idx*GSIZE, posy_o = Y0.
  - Otherwise: character = 8'h20 (space), posx_o = X0, posy_o = Y0.
- Visible count update and decode use the same cycle's registered state; reveal takes effect from the pixel after the tick.
- Reset mid-operation: immediate return to IDLE, len cleared, all outputs to reset values.

## Timing
- character, posx_o, posy_o, RGBStr_o registered; latency 1 px_clk from RGBStr_i, all mutually aligned.
- Reset values: RGBStr_o 0, character 8'h20, posx_o 0, posy_o 0, busy 0, done 0. wr_ready follows state: 1 in IDLE with start low.
- busy rises the cycle after the accepted start and falls the cycle after done.
- Total playback: (len−1)*FRAME_DIV + HOLD_FRAMES frame ticks from start to done.

## Structure
- Shared package: state encoding, SPACE code 8'h20, derived widths (clog2 of MSG_LEN and GSIZE, frame counter width).
- One sub-module: pxs_frame_tick (coordinate edge detector producing the frame tick), reusable by other animated stages.
- Buffer is an MSG_LEN×8 register array with a single write port and an asynchronous read.

## Test plan
- Load "HI" (8'h48, 8'h49 with wr_last), start. Pixel at (X0, Y0) -> character 8'h48, posx_o X0 one cycle later. Pixel at (X0+16, Y0) -> 8'h20 until FRAME_DIV ticks, then 8'h49, posx_o X0+16.
- Pixel at (X0−1, Y0) and at (X0, Y0+GSIZE) -> space, posx_o X0, every state.
- 16-byte load without wr_last -> len 16, wr_ptr wraps to 0. Playback reveals all 16; done pulses after 15*FRAME_DIV+HOLD_FRAMES ticks.
- start with len 0 -> stays IDLE, busy 0. start during TYPE -> no effect on visible or counter.
- rst_n low mid-TYPE -> next cycle: busy 0, character 8'h20, wr_ready 1. A following start is ignored (len 0).
- wr_valid and start asserted in the same IDLE cycle -> byte not accepted (wr_ready 0), playback starts with the previous len.

Source files
------------

// File: rtl/text_typewriter_ctrl_pkg.sv
// Shared types and constants for the typewriter text sequencer and its helpers.
// RGB stream layout: XC in [25:16], YC in [15:6], colour bits in [5:0].
package text_typewriter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TYPE = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [7:0] SPACE = 8'h20;

  localparam int RGB_W   = 26;
  localparam int COORD_W = 10;
  localparam int XC_LSB  = 16;
  localparam int YC_LSB  = 6;

  localparam int MSG_LEN_DEF     = 16;
  localparam int GSIZE_DEF       = 16;
  localparam int FRAME_DIV_DEF   = 8;
  localparam int HOLD_FRAMES_DEF = 60;

  // Width of a counter that must reach max(a,b)-1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

  localparam int PTR_W_DEF = $clog2(MSG_LEN_DEF);
  localparam int GLOG_DEF  = $clog2(GSIZE_DEF);
  localparam int CNT_W_DEF = cnt_width(FRAME_DIV_DEF, HOLD_FRAMES_DEF);

endpackage

// File: rtl/text_typewriter_ctrl_if.sv
// Message load port: valid/ready byte stream with an end-of-message marker.
interface text_typewriter_ctrl_if;

  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_last;
  logic       wr_ready;

  modport master (output wr_valid, output wr_data, output wr_last, input wr_ready);
  modport slave  (input wr_valid, input wr_data, input wr_last, output wr_ready);

endinterface

// File: rtl/text_typewriter_ctrl_pxs_frame_tick.sv
// Frame-start detector: pulses for one cycle on the first pixel at (0,0).
// Combinational on the current pixel so consumers act in the same cycle.
module pxs_frame_tick
  import text_typewriter_ctrl_pkg::*;
(
  input  logic               px_clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] xc,
  input  logic [COORD_W-1:0] yc,
  output logic               tick
);

  logic origin_s;
  logic origin_d_r;

  assign origin_s = (xc == 10'd0) && (yc == 10'd0);

  // Remember whether the previous pixel was already the origin.
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      origin_d_r <= 1'b0;
    end else begin
      origin_d_r <= origin_s;
    end
  end

  assign tick = origin_s && !origin_d_r;

endmodule

// File: rtl/text_typewriter_ctrl.sv
// Typewriter sequencer: stores a message, reveals it one glyph per FRAME_DIV
// frames and tells the downstream character stage what to draw at each pixel.
module text_typewriter_ctrl
  import text_typewriter_ctrl_pkg::*;
#(
  parameter int MSG_LEN     = MSG_LEN_DEF,
  parameter int GSIZE       = GSIZE_DEF,
  parameter int X0          = 64,
  parameter int Y0          = 32,
  parameter int FRAME_DIV   = FRAME_DIV_DEF,
  parameter int HOLD_FRAMES = HOLD_FRAMES_DEF
) (
  input  logic                   px_clk,
  input  logic                   rst_n,
  input  logic [RGB_W-1:0]       RGBStr_i,
  text_typewriter_ctrl_if.slave  wr,
  input  logic                   start,
  output logic [RGB_W-1:0]       RGBStr_o,
  output logic [7:0]             character,
  output logic [COORD_W-1:0]     posx_o,
  output logic [COORD_W-1:0]     posy_o,
  output logic                   busy,
  output logic                   done
);

  localparam int PTR_W = (MSG_LEN <= 2) ? 1 : $clog2(MSG_LEN);
  localparam int LEN_W = PTR_W + 1;
  localparam int GLOG  = $clog2(GSIZE);
  localparam int CNT_W = cnt_width(FRAME_DIV, HOLD_FRAMES);

  state_t             state_r;
  logic [7:0]         buf_r [MSG_LEN];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   vis_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               busy_r;
  logic               done_r;
  logic [RGB_W-1:0]   rgb_r;
  logic [7:0]         char_r;
  logic [COORD_W-1:0] posx_r;
  logic [COORD_W-1:0] posy_r;

  logic [COORD_W-1:0] xc_s;
  logic [COORD_W-1:0] yc_s;
  logic               tick_s;
  logic               wr_accept_s;
  logic [COORD_W:0]   row_end_s;
  logic               in_row_s;
  logic               in_col_s;
  logic [COORD_W-1:0] off_s;
  logic [COORD_W-1:0] idx_s;
  logic               hit_s;
  logic [7:0]         char_s;
  logic [COORD_W-1:0] posx_s;
  logic [COORD_W-1:0] posy_s;

  assign xc_s = RGBStr_i[XC_LSB +: COORD_W];
  assign yc_s = RGBStr_i[YC_LSB +: COORD_W];

  pxs_frame_tick u_frame_tick (
    .px_clk (px_clk),
    .rst_n  (rst_n),
    .xc     (xc_s),
    .yc     (yc_s),
    .tick   (tick_s)
  );

  // A start pulse has priority over a byte offered in the same cycle.
  assign wr.wr_ready  = (state_r == ST_IDLE) && !start;
  assign wr_accept_s  = wr.wr_valid && wr.wr_ready;

  // Message buffer: single write port, read asynchronously by the decoder.
  always_ff @(posedge px_clk) begin
    if (wr_accept_s) begin
      buf_r[wr_ptr_r] <= wr.wr_data;
    end
  end

  // Cell decode; row end is computed one bit wider so Y0+GSIZE=1024 works.
  always_comb begin
    row_end_s = (COORD_W+1)'(Y0) + (COORD_W+1)'(GSIZE);
    in_row_s  = (yc_s >= 10'(Y0)) && ({1'b0, yc_s} < row_end_s);
    in_col_s  = (xc_s >= 10'(X0));
    off_s     = xc_s - 10'(X0);
    idx_s     = off_s >> GLOG;
    hit_s     = in_row_s && in_col_s && (idx_s < 10'(vis_r));
    char_s    = SPACE;
    posx_s    = 10'(X0);
    posy_s    = 10'(Y0);
    if (hit_s) begin
      char_s = buf_r[idx_s[PTR_W-1:0]];
      posx_s = 10'(X0) + (idx_s << GLOG);
    end else begin
      char_s = SPACE;
      posx_s = 10'(X0);
    end
  end

  // Playback FSM together with message pointer/length bookkeeping.
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      wr_ptr_r <= '0;
      len_r    <= '0;
      vis_r    <= '0;
      cnt_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (wr_accept_s) begin
        if (wr.wr_last || (wr_ptr_r == PTR_W'(MSG_LEN-1))) begin
          len_r    <= LEN_W'(wr_ptr_r) + LEN_W'(1);
          wr_ptr_r <= '0;
        end else begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        end
      end
      case (state_r)
        ST_IDLE: begin
          busy_r <= 1'b0;
          if (start && (len_r != '0)) begin
            vis_r   <= LEN_W'(1);
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            // A one-glyph message is fully shown at once and goes straight to hold.
            state_r <= (len_r == LEN_W'(1)) ? ST_HOLD : ST_TYPE;
          end
        end
        ST_TYPE: begin
          busy_r <= 1'b1;
          if (tick_s) begin
            if (cnt_r == CNT_W'(FRAME_DIV-1)) begin
              cnt_r <= '0;
              vis_r <= vis_r + LEN_W'(1);
              if ((vis_r + LEN_W'(1)) == len_r) begin
                state_r <= ST_HOLD;
              end
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          busy_r <= 1'b1;
          if (tick_s) begin
            if (cnt_r == CNT_W'(HOLD_FRAMES-1)) begin
              done_r  <= 1'b1;
              vis_r   <= '0;
              cnt_r   <= '0;
              state_r <= ST_IDLE;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Registered, mutually aligned outputs toward the character stage.
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_r  <= '0;
      char_r <= SPACE;
      posx_r <= '0;
      posy_r <= '0;
    end else begin
      rgb_r  <= RGBStr_i;
      char_r <= char_s;
      posx_r <= posx_s;
      posy_r <= posy_s;
    end
  end

  assign RGBStr_o  = rgb_r;
  assign character = char_r;
  assign posx_o    = posx_r;
  assign posy_o    = posy_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_text_typewriter_ctrl.sv
// Directed bench for text_typewriter_ctrl with a behavioural model and a
// pixel scoreboard; drives one tick per two-pixel "frame".
module tb_text_typewriter_ctrl;

  localparam int X0 = 64;
  localparam int Y0 = 32;
  localparam int GS = 16;
  localparam int FD = 8;
  localparam int HF = 60;
  localparam int ML = 16;

  logic        px_clk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic [25:0] RGBStr_i = '0;
  logic [25:0] RGBStr_o;
  logic [7:0]  character;
  logic [9:0]  posx_o;
  logic [9:0]  posy_o;
  logic        busy;
  logic        done;

  text_typewriter_ctrl_if wr_if ();

  text_typewriter_ctrl #(
    .MSG_LEN(ML), .GSIZE(GS), .X0(X0), .Y0(Y0), .FRAME_DIV(FD), .HOLD_FRAMES(HF)
  ) dut (
    .px_clk   (px_clk),
    .rst_n    (rst_n),
    .RGBStr_i (RGBStr_i),
    .wr       (wr_if.slave),
    .start    (start),
    .RGBStr_o (RGBStr_o),
    .character(character),
    .posx_o   (posx_o),
    .posy_o   (posy_o),
    .busy     (busy),
    .done     (done)
  );

  always #5 px_clk = ~px_clk;

  typedef struct packed {
    logic [7:0]  ch;
    logic [9:0]  px;
    logic [9:0]  py;
    logic [25:0] rgb;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         m_state, m_cnt, m_vis, m_len, m_wptr;
  logic [7:0] msg_m [ML];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] mk(input int x, input int y);
    logic [9:0] xv;
    logic [9:0] yv;
    xv = 10'(x);
    yv = 10'(y);
    return {xv, yv, 6'h2A};
  endfunction

  function automatic exp_t model_cell(input int x, input int y);
    exp_t e;
    int   idx;
    e.rgb = mk(x, y);
    e.ch  = 8'h20;
    e.px  = 10'(X0);
    e.py  = 10'(Y0);
    if (y >= Y0 && y < Y0 + GS && x >= X0) begin
      idx = (x - X0) / GS;
      if (idx < m_vis) begin
        e.ch = msg_m[idx];
        e.px = 10'(X0 + idx * GS);
      end
    end
    return e;
  endfunction

  task automatic step();
    @(posedge px_clk);
    #1;
  endtask

  task automatic pix(input string tag, input int x, input int y);
    exp_t e;
    RGBStr_i = mk(x, y);
    sb_q.push_back(model_cell(x, y));
    step();
    e = sb_q.pop_front();
    chk({tag, ".char"}, character, e.ch);
    chk({tag, ".posx"}, posx_o, e.px);
    chk({tag, ".posy"}, posy_o, e.py);
    chk({tag, ".rgb"},  RGBStr_o, e.rgb);
  endtask

  task automatic model_tick(output logic dexp);
    dexp = 1'b0;
    if (m_state == 1) begin
      if (m_cnt == FD - 1) begin
        m_cnt = 0;
        m_vis++;
        if (m_vis == m_len) m_state = 2;
      end else begin
        m_cnt++;
      end
    end else if (m_state == 2) begin
      if (m_cnt == HF - 1) begin
        dexp    = 1'b1;
        m_vis   = 0;
        m_cnt   = 0;
        m_state = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic tick();
    logic dexp;
    pix("tick", 0, 0);
    model_tick(dexp);
    chk("done_at_tick", done, dexp);
    chk("busy_at_tick", busy, ((m_state != 0) || dexp) ? 1 : 0);
    pix("gap", 1, 1);
    chk("done_gap", done, 0);
    chk("busy_gap", busy, (m_state != 0) ? 1 : 0);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic last);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = d;
    wr_if.wr_last  = last;
    #1;
    chk("wr_ready_idle", wr_if.wr_ready, 1);
    step();
    wr_if.wr_valid = 1'b0;
    wr_if.wr_last  = 1'b0;
    msg_m[m_wptr] = d;
    if (last || m_wptr == ML - 1) begin
      m_len  = m_wptr + 1;
      m_wptr = 0;
    end else begin
      m_wptr++;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    if (m_state == 0 && m_len != 0) begin
      m_vis   = 1;
      m_cnt   = 0;
      m_state = (m_len == 1) ? 2 : 1;
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_vis = 0; m_len = 0; m_wptr = 0;
  endtask

  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = 8'h00;
    wr_if.wr_last  = 1'b0;
    RGBStr_i = mk(1, 1);
    model_reset();
    for (int i = 0; i < ML; i++) msg_m[i] = 8'h00;

    // Reset values
    step();
    step();
    chk("rst.rgb",  RGBStr_o, 0);
    chk("rst.char", character, 8'h20);
    chk("rst.posx", posx_o, 0);
    chk("rst.posy", posy_o, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.wr_ready", wr_if.wr_ready, 1);
    rst_n = 1'b1;
    step();

    // start with empty buffer is ignored; wr_ready drops while start is high
    start = 1'b1;
    #1;
    chk("wr_ready_start", wr_if.wr_ready, 0);
    step();
    start = 1'b0;
    chk("empty_start.busy", busy, 0);
    step();
    chk("empty_start.busy2", busy, 0);

    // Load "HI" and play
    wr_byte(8'h48, 1'b0);
    wr_byte(8'h49, 1'b1);
    pulse_start();
    chk("hi.busy_rise", busy, 1);
    chk("hi.wr_ready_busy", wr_if.wr_ready, 0);
    pix("hi.c0", X0, Y0);
    pix("hi.c1_hidden", X0 + 16, Y0);
    pix("hi.left", X0 - 1, Y0);
    pix("hi.below", X0, Y0 + GS);
    tick();
    pulse_start();
    for (int i = 0; i < FD - 1; i++) begin
      tick();
      pix("hi.c1", X0 + 16 + 5, Y0 + 3);
    end
    pix("hold.left", X0 - 1, Y0);
    pix("hold.below", X0 + 16, Y0 + GS);
    run_ticks(HF);
    chk("hi.idle_after", busy, 0);
    pix("idle.c0", X0, Y0);

    // Byte offered together with start: not written, replay with len 2
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = 8'h41;
    wr_if.wr_last  = 1'b1;
    start = 1'b1;
    #1;
    chk("wr_start.ready", wr_if.wr_ready, 0);
    step();
    wr_if.wr_valid = 1'b0;
    wr_if.wr_last  = 1'b0;
    start = 1'b0;
    if (m_state == 0 && m_len != 0) begin
      m_vis = 1; m_cnt = 0; m_state = (m_len == 1) ? 2 : 1;
    end
    chk("wr_start.busy", busy, 1);
    pix("wr_start.c0", X0, Y0);
    run_ticks(FD + HF);
    chk("wr_start.idle", busy, 0);

    // Full 16-byte load without wr_last
    for (int i = 0; i < ML; i++) wr_byte(8'h60 + 8'(i), 1'b0);
    pulse_start();
    run_ticks(15 * FD);
    pix("full.c15", X0 + 15 * GS + 3, Y0 + 5);
    pix("full.c7", X0 + 7 * GS, Y0 + GS - 1);
    pix("full.past", X0 + 16 * GS, Y0);
    run_ticks(HF);
    chk("full.idle", busy, 0);

    // Pointer wrapped: next byte lands in slot 0, one-glyph message
    wr_byte(8'h7A, 1'b1);
    pulse_start();
    chk("one.busy", busy, 1);
    pix("one.c0", X0, Y0);
    pix("one.c1", X0 + 16, Y0);
    run_ticks(HF);
    chk("one.idle", busy, 0);

    // Reset during TYPE
    wr_byte(8'h31, 1'b0);
    wr_byte(8'h32, 1'b0);
    wr_byte(8'h33, 1'b1);
    pulse_start();
    run_ticks(3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.busy", busy, 0);
    chk("rst_mid.char", character, 8'h20);
    chk("rst_mid.posx", posx_o, 0);
    chk("rst_mid.wr_ready", wr_if.wr_ready, 1);
    step();
    rst_n = 1'b1;
    model_reset();
    pulse_start();
    chk("rst_mid.start_ignored", busy, 0);
    step();
    chk("rst_mid.start_ignored2", busy, 0);
    pix("rst_mid.c0", X0, Y0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
